// File: rtl/serial_mult_engine_if.sv
// Purpose : byte-stream bundle between a tile top and serial_mult_engine.
// Ports   : in_valid/in_data/in_ready carry operand bytes towards the engine;
//           out_valid/out_data/out_last/out_ready carry product bytes back out.
interface serial_mult_engine_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    // master: the side that feeds operands and drains the product
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // slave: the multiplier engine itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/serial_mult_engine.sv
// Purpose : byte-serial shift-add multiplier. Loads A then B (MSB byte first),
//           does one multiplier bit per enabled cycle, then streams the
//           2*OP_BYTES-byte product out MSB first.
// Latency : first product byte valid W+1 enabled cycles after the last B byte.
// Backpr. : in_ready low outside LOAD_A/LOAD_B; out_ready low holds out_data.
// Ports   : clk, rst_n (async active-low), ena (global clock enable), clr
//           (sync abort), signed_mode (latched with first A byte), bus (slave
//           side of serial_mult_engine_if), busy (operation in progress).
module serial_mult_engine #(
    parameter int OP_BYTES  = 3,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 clr,
    input  logic                 signed_mode,
    serial_mult_engine_if.slave  bus,
    output logic                 busy
);
    localparam int W  = 8 * OP_BYTES;
    localparam int P  = 2 * W;
    localparam int CW = $clog2(W + 1);

    localparam logic [CW-1:0] LAST_OP  = CW'(OP_BYTES - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(2 * OP_BYTES - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   a_q;
    logic [W-1:0]   mplier;   // holds B while loading, then shifts right during COMPUTE
    logic [P-1:0]   mcand;    // A extended to P bits, shifted left each step
    logic [P-1:0]   acc;      // running product; shifted left by a byte per output transfer
    logic           sgn;

    logic           in_xfer;
    logic           out_xfer;
    logic [P-1:0]   a_ext;
    logic [P-1:0]   acc_step;

    assign bus.in_ready  = ena && (state == LOAD_A || state == LOAD_B);
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_data  = acc[P-1 -: 8];
    assign bus.out_last  = (state == DRAIN) && (cnt == LAST_OUT);
    assign busy          = (state != LOAD_A) || (cnt != '0);

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready && ena;

    assign a_ext = sgn ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};

    // In two's-complement the multiplier MSB carries weight -2^(W-1), so that
    // partial product is subtracted instead of added; everything is mod 2^P.
    always_comb begin
        acc_step = acc;
        if (mplier[0]) begin
            if (sgn && cnt == LAST_BIT)
                acc_step = acc - mcand;
            else
                acc_step = acc + mcand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD_A;
            cnt    <= '0;
            a_q    <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            sgn    <= 1'b0;
        end else if (ena) begin
            if (clr) begin
                state <= LOAD_A;
                cnt   <= '0;
            end else begin
                case (state)
                    LOAD_A: if (in_xfer) begin
                        a_q <= W'({a_q, bus.in_data});
                        if (cnt == '0)
                            sgn <= SIGNED_EN && signed_mode;
                        if (cnt == LAST_OP) begin
                            state <= LOAD_B;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    LOAD_B: if (in_xfer) begin
                        mplier <= W'({mplier, bus.in_data});
                        if (cnt == LAST_OP) begin
                            state <= COMPUTE;
                            cnt   <= '0;
                            mcand <= a_ext;
                            acc   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    COMPUTE: begin
                        acc    <= acc_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (cnt == LAST_BIT) begin
                            state <= DRAIN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DRAIN: if (out_xfer) begin
                        acc <= acc << 8;
                        if (cnt == LAST_OUT) begin
                            state <= LOAD_A;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= LOAD_A;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_mult_engine.sv
// Purpose : scoreboard bench for serial_mult_engine (OP_BYTES=3). Stimulus
//           pushes expected product bytes; an independent monitor pops and
//           compares on every output transfer.
module tb_serial_mult_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    logic clr = 1'b0;
    logic signed_mode = 1'b0;
    logic busy;

    serial_mult_engine_if bus();

    serial_mult_engine #(.OP_BYTES(3), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .clr         (clr),
        .signed_mode (signed_mode),
        .bus         (bus.slave),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } exp_t;
    exp_t q[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- monitor ----------------
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    exp_t       e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && prev_stall)
                check("stall_stable", bus.out_data, prev_d);
            if (bus.out_valid)
                check("in_ready_low_drain", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready && ena && !clr) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got %0h expected none", bus.out_data);
                end else begin
                    e = q.pop_front();
                    check("out_data", bus.out_data, e.d);
                    check("out_last", bus.out_last, e.last);
                end
            end
            prev_stall = bus.out_valid && !(bus.out_ready && ena);
            prev_d     = bus.out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap, output int acc_cyc);
        int n;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        check("in_accept", (n < 50), 1);
        acc_cyc = cyc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic load_op(input logic [23:0] a, input logic [23:0] b, input logic sm,
                           input int gap, input int nb, output int t_last);
        int t;
        t = 0;
        signed_mode = sm;
        for (int i = 0; i < 3; i++) send_byte(a[23-8*i -: 8], (i == 0) ? 0 : gap, t);
        for (int i = 0; i < nb; i++) send_byte(b[23-8*i -: 8], gap, t);
        t_last = t;
    endtask

    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic sm,
                          input logic [47:0] p, input int gap, input bit toggle,
                          input bit hold_c, input bit hold_d);
        int   t, n, k;
        bit   got, ir_bad;
        exp_t x;
        for (int i = 0; i < 6; i++) begin
            x.d    = p[47-8*i -: 8];
            x.last = (i == 5);
            q.push_back(x);
        end
        ena = 1'b1;
        bus.out_ready = 1'b1;
        load_op(a, b, sm, gap, 3, t);
        got = 0;
        ir_bad = 0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1;
                break;
            end
            if (bus.in_ready) ir_bad = 1;
            tick();
            ena = !(hold_c && (cyc - t) >= 11 && (cyc - t) < 16);
        end
        check("valid_seen", got, 1);
        check("latency", cyc - t, hold_c ? 30 : 25);
        check("in_ready_low_compute", ir_bad, 0);
        for (k = 0; k < 200; k++) begin
            tick();
            ena = !(hold_d && k >= 2 && k < 7);
            bus.out_ready = toggle ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid) break;
        end
        check("drain_done", (k < 200), 1);
        check("idle_busy", busy, 0);
        check("idle_in_ready", bus.in_ready, 1);
        ena = 1'b1;
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        int t;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op(24'h000003, 24'h000005, 1'b0, 48'h00000000000F, 0, 0, 0, 0);
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, 0, 0, 0, 0);
        run_op(24'hFFFFFF, 24'h000002, 1'b1, 48'hFFFFFFFFFFFE, 0, 0, 0, 0);
        run_op(24'h800000, 24'h800000, 1'b1, 48'h400000000000, 0, 0, 0, 0);
        run_op(24'h800000, 24'h800000, 1'b0, 48'h400000000000, 0, 0, 0, 0);
        run_op(24'h800000, 24'h000001, 1'b1, 48'hFFFFFF800000, 0, 0, 0, 0);
        // input gaps plus out_ready toggling
        run_op(24'h000102, 24'h000304, 1'b0, 48'h000000030A08, 2, 1, 0, 0);
        // ena dropped for 5 cycles in COMPUTE and in DRAIN
        run_op(24'hFFFFFE, 24'h000003, 1'b1, 48'hFFFFFFFFFFFA, 0, 0, 1, 1);

        // abort after two B bytes
        load_op(24'h000007, 24'h000006, 1'b0, 0, 2, t);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_out_valid", bus.out_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_in_ready", bus.in_ready, 1);
        tick();

        // reset in the middle of COMPUTE
        load_op(24'h000007, 24'h000006, 1'b0, 0, 3, t);
        repeat (5) tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", bus.in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        run_op(24'h000007, 24'h000006, 1'b0, 48'h00000000002A, 0, 0, 0, 0);

        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
